ami_copy_initiator: RTL and testbench

- AMI-side memory initiator (requester) for the DNNWeaver harness.
- Copies a contiguous region: issues 64-byte reads on AMI port 0, buffers the in-order read responses in a small FIFO, then issues 64-byte writes of that data on AMI port 1.
- Used to preload and relocate weight and activation images in the memory model before and after `dnnweaver_ami_top` runs.
- Credit-limited: never has more reads in flight than FIFO space can absorb.

---
 rtl/ami_copy_initiator.sv | 169 ++++++++++++++++
 tb/tb_ami_copy_initiator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_copy_initiator.sv
// AMI copy initiator: streams num_beats 64-byte beats from src (port 0 reads) to dst (port 1 writes)
// through a credit-limited response FIFO. Optional counters under AMI_COPY_STATS_EN.
module ami_copy_initiator #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int SIZE_W     = 8,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  num_beats,
  output logic              busy,
  output logic              done,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [SIZE_W-1:0] rd_req_size,
  input  logic              rd_req_grant,
  input  logic              rd_resp_valid,
  input  logic [DATA_W-1:0] rd_resp_data,
  output logic              rd_resp_grant,
  output logic              wr_req_valid,
  output logic              wr_req_isWrite,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [DATA_W-1:0] wr_req_data,
  output logic [SIZE_W-1:0] wr_req_size,
  input  logic              wr_req_grant,
  output logic              err_stray_resp
`ifdef AMI_COPY_STATS_EN
  ,
  output logic [63:0]       cycle_count,
  output logic [31:0]       rd_stall_count,
  output logic [31:0]       wr_stall_count
`endif
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | read and write engines active
  // FINISH | all writes issued; done pulses on the way back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_issued;
  logic [LEN_W-1:0]  wr_issued;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [CNT_W:0]    credit;
  logic              rd_fire;
  logic              wr_fire;
  logic              push;
  logic              stray;

  // Reads are only issued while outstanding + buffered beats leave room, so a push never overflows.
  assign credit       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign rd_req_valid = (state == RUN) && (rd_issued < len_q) &&
                        (credit < (CNT_W+1)'(FIFO_DEPTH));
  assign rd_req_addr  = src_q + (ADDR_W'(rd_issued) << 6);
  assign rd_req_size  = SIZE_W'(64);
  assign rd_resp_grant = rd_resp_valid;

  assign wr_req_valid   = (state == RUN) && (fifo_count != '0);
  assign wr_req_isWrite = 1'b1;
  assign wr_req_addr    = dst_q + (ADDR_W'(wr_issued) << 6);
  assign wr_req_data    = fifo_mem[rd_ptr];
  assign wr_req_size    = SIZE_W'(64);

  assign rd_fire = rd_req_valid && rd_req_grant;
  assign wr_fire = wr_req_valid && wr_req_grant;
  assign push    = rd_resp_valid && (outstanding != '0);
  assign stray   = rd_resp_valid && (outstanding == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      rd_issued      <= '0;
      wr_issued      <= '0;
      outstanding    <= '0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      err_stray_resp <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
`ifdef AMI_COPY_STATS_EN
      cycle_count    <= '0;
      rd_stall_count <= '0;
      wr_stall_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            len_q     <= num_beats;
            rd_issued <= '0;
            wr_issued <= '0;
            state     <= (num_beats == '0) ? FINISH : RUN;
`ifdef AMI_COPY_STATS_EN
            cycle_count <= '0;
`endif
          end
        end
        RUN: begin
          if (wr_issued == len_q) state <= FINISH;
`ifdef AMI_COPY_STATS_EN
          cycle_count <= cycle_count + 64'd1;
`endif
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (rd_fire) rd_issued <= rd_issued + 1'b1;

      case ({rd_fire, push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (push) begin
        fifo_mem[wr_ptr] <= rd_resp_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (stray) err_stray_resp <= 1'b1;

      if (wr_fire) begin
        rd_ptr    <= rd_ptr + 1'b1;
        wr_issued <= wr_issued + 1'b1;
      end

      case ({push, wr_fire})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

`ifdef AMI_COPY_STATS_EN
      if (rd_req_valid && !rd_req_grant) rd_stall_count <= rd_stall_count + 32'd1;
      if (wr_req_valid && !wr_req_grant) wr_stall_count <= wr_stall_count + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_ami_copy_initiator.sv
// Bench for ami_copy_initiator: table of copy jobs driven through a memory model with a write scoreboard,
// plus hand sequences for credit limiting, grant stalls, mid-copy reset and start-while-busy.
module tb_ami_copy_initiator;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  src_addr, dst_addr;
  logic [15:0]  num_beats;
  logic         busy, done;
  logic         rd_req_valid;
  logic [63:0]  rd_req_addr;
  logic [7:0]   rd_req_size;
  logic         rd_req_grant;
  logic         rd_resp_valid;
  logic [511:0] rd_resp_data;
  logic         rd_resp_grant;
  logic         wr_req_valid, wr_req_isWrite;
  logic [63:0]  wr_req_addr;
  logic [511:0] wr_req_data;
  logic [7:0]   wr_req_size;
  logic         wr_req_grant;
  logic         err_stray_resp;
`ifdef AMI_COPY_STATS_EN
  logic [63:0]  cycle_count;
  logic [31:0]  rd_stall_count, wr_stall_count;
`endif

  ami_copy_initiator dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_beats(num_beats), .busy(busy), .done(done),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_size(rd_req_size),
    .rd_req_grant(rd_req_grant), .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .rd_resp_grant(rd_resp_grant), .wr_req_valid(wr_req_valid), .wr_req_isWrite(wr_req_isWrite),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_size(wr_req_size),
    .wr_req_grant(wr_req_grant), .err_stray_resp(err_stray_resp)
`ifdef AMI_COPY_STATS_EN
    , .cycle_count(cycle_count), .rd_stall_count(rd_stall_count), .wr_stall_count(wr_stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    int nb, lat, rdm, wrm;
    int first_rd_off, first_wr_off, done_off, any_valid;
  } job_t;
  typedef struct { int due; logic [511:0] data; } resp_t;
  typedef struct { logic [63:0] addr; logic [511:0] data; } wr_t;

  resp_t resp_q[$];
  wr_t   sb[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int rd_mode = 0, wr_mode = 0, resp_lat = 2;
  logic [63:0] cur_src, cur_dst;
  int rd_cnt, wr_cnt, done_cnt, start_cyc, first_rd, first_wr, done_cyc;
  logic any_valid, busy_at_done;
  logic last_rd_valid, last_wr_valid, last_busy, last_done, last_resp_grant;
  logic [63:0] last_rd_addr;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_data(string name, logic [511:0] act, logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [511:0] mkdata(logic [63:0] a);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = a ^ (64'h1111_1111_1111_1111 * 64'(i + 1));
    return d;
  endfunction

  function automatic logic gnt(int m);
    if (m == 0) return 1'b1;
    if (m == 1) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive_and_sample();
    logic [63:0] exp_a;
    wr_t e;
    if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
      rd_resp_valid = 1'b1;
      rd_resp_data  = resp_q[0].data;
      void'(resp_q.pop_front());
    end else begin
      rd_resp_valid = 1'b0;
      rd_resp_data  = '0;
    end
    rd_req_grant = gnt(rd_mode);
    wr_req_grant = gnt(wr_mode);
    #1;
    last_rd_valid = rd_req_valid; last_rd_addr = rd_req_addr;
    last_wr_valid = wr_req_valid; last_busy = busy; last_done = done;
    last_resp_grant = rd_resp_grant;
    if (rd_req_valid || wr_req_valid) any_valid = 1'b1;
    if (rd_req_valid && rd_req_grant) begin
      exp_a = cur_src + 64'(rd_cnt) * 64;
      chk("rd_addr", rd_req_addr, exp_a);
      resp_q.push_back('{due: cyc + resp_lat, data: mkdata(exp_a)});
      sb.push_back('{addr: cur_dst + 64'(rd_cnt) * 64, data: mkdata(exp_a)});
      if (first_rd < 0) first_rd = cyc;
      rd_cnt++;
    end
    if (wr_req_valid && wr_req_grant) begin
      chk("wr_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", wr_req_addr, e.addr);
        chk_data("wr_data", wr_req_data, e.data);
      end
      if (first_wr < 0) first_wr = cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic step(input bit restart);
    @(negedge clk);
    start = restart;
    if (restart) begin
      src_addr = 64'hDEAD_0000; dst_addr = 64'hBEEF_0000; num_beats = 16'd2;
    end
    drive_and_sample();
  endtask

  task automatic start_job(input logic [63:0] s, input logic [63:0] d, input int n);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; num_beats = 16'(n);
    cur_src = s; cur_dst = d;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; first_rd = -1; first_wr = -1; done_cyc = -1;
    any_valid = 1'b0; busy_at_done = 1'b0; start_cyc = cyc;
    drive_and_sample();
  endtask

  task automatic finish_job(input int n, input int restart_at, input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) step(k + 1 == restart_at);
    chk("done_seen", 64'(done_cnt), 64'd1);
    chk("busy_at_done", 64'(busy_at_done), 64'd1);
    step(1'b0);
    chk("busy_after_done", 64'(last_busy), 64'd0);
    chk("done_one_cycle", 64'(last_done), 64'd0);
    chk("rd_count", 64'(rd_cnt), 64'(n));
    chk("wr_count", 64'(wr_cnt), 64'(n));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("no_rd_after_done", 64'(last_rd_valid), 64'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_rd_addr", rd_req_addr, 64'd0);
    chk("rst_rd_size", 64'(rd_req_size), 64'd64);
    chk("rst_wr_valid", 64'(wr_req_valid), 64'd0);
    chk("rst_wr_iswrite", 64'(wr_req_isWrite), 64'd1);
    chk("rst_wr_addr", wr_req_addr, 64'd0);
    chk("rst_wr_size", 64'(wr_req_size), 64'd64);
    chk_data("rst_wr_data", wr_req_data, '0);
    chk("rst_err", 64'(err_stray_resp), 64'd0);
`ifdef AMI_COPY_STATS_EN
    chk("rst_cycle_count", cycle_count, 64'd0);
    chk("rst_rd_stall", 64'(rd_stall_count), 64'd0);
    chk("rst_wr_stall", 64'(wr_stall_count), 64'd0);
`endif
  endtask

  job_t jobs[6];

  initial begin
    jobs[0] = '{64'h1000, 64'h8000, 3, 2, 0, 0, 1, 4, -1, 1};
    jobs[1] = '{64'h0, 64'h0, 0, 2, 0, 0, -1, -1, 2, 0};
    jobs[2] = '{64'h2000_0000, 64'h3000_0000, 7, 1, 2, 2, -1, -1, -1, 1};
    jobs[3] = '{64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 3, 3, 0, 2, -1, -1, -1, 1};
    jobs[4] = '{64'h4_0000, 64'h8_0000, 1, 2, 2, 0, -1, -1, -1, 1};
    jobs[5] = '{64'h0, 64'h10_0000, 16, 3, 0, 0, -1, -1, -1, 1};

    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; num_beats = '0;
    rd_req_grant = 1'b0; wr_req_grant = 1'b0; rd_resp_valid = 1'b0; rd_resp_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    foreach (jobs[i]) begin
      rd_mode = jobs[i].rdm; wr_mode = jobs[i].wrm; resp_lat = jobs[i].lat;
      start_job(jobs[i].src, jobs[i].dst, jobs[i].nb);
      finish_job(jobs[i].nb, 0, 500);
      chk("any_valid", 64'(any_valid), 64'(jobs[i].any_valid));
      if (jobs[i].first_rd_off >= 0) chk("first_rd_latency", 64'(first_rd - start_cyc), 64'(jobs[i].first_rd_off));
      if (jobs[i].first_wr_off >= 0) chk("first_wr_latency", 64'(first_wr - start_cyc), 64'(jobs[i].first_wr_off));
      if (jobs[i].done_off >= 0) chk("done_latency", 64'(done_cyc - start_cyc), 64'(jobs[i].done_off));
    end

    // Credit limit: writes blocked, so only FIFO_DEPTH reads may be issued.
    rd_mode = 0; wr_mode = 1; resp_lat = 2;
    start_job(64'h7_0000, 64'h9_0000, 10);
    repeat (20) step(1'b0);
    chk("credit_reads", 64'(rd_cnt), 64'd4);
    chk("credit_rd_valid_low", 64'(last_rd_valid), 64'd0);
    chk("credit_no_writes", 64'(wr_cnt), 64'd0);
    wr_mode = 0;
    finish_job(10, 0, 500);

    // Read grant withheld: request must hold steady.
    begin
`ifdef AMI_COPY_STATS_EN
      logic [31:0] snap;
`endif
      rd_mode = 1; wr_mode = 0; resp_lat = 2;
      start_job(64'hA000, 64'hC000, 4);
`ifdef AMI_COPY_STATS_EN
      #2 snap = rd_stall_count;
`endif
      for (int k = 0; k < 5; k++) begin
        step(1'b0);
        chk("stall_rd_valid", 64'(last_rd_valid), 64'd1);
        chk("stall_rd_addr", last_rd_addr, 64'hA000);
      end
`ifdef AMI_COPY_STATS_EN
      #2 chk("rd_stall_count", 64'(rd_stall_count - snap), 64'd5);
`endif
      rd_mode = 0;
      finish_job(4, 0, 500);
    end

    // Start while busy is ignored.
    rd_mode = 0; wr_mode = 2; resp_lat = 2;
    start_job(64'h5000, 64'h6000, 5);
    finish_job(5, 3, 500);

    chk("no_err_before_stray", 64'(err_stray_resp), 64'd0);

    // Reset mid-copy after two writes, then a stray response.
    rd_mode = 0; wr_mode = 0; resp_lat = 2;
    start_job(64'hE000, 64'hF000, 8);
    for (int k = 0; k < 200 && wr_cnt < 2; k++) step(1'b0);
    chk("t5_two_writes", 64'(wr_cnt), 64'd2);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; rd_req_grant = 1'b0; wr_req_grant = 1'b0;
    rd_resp_valid = 1'b0; rd_resp_data = '0;
    resp_q.delete(); sb.delete();
    @(posedge clk); cyc++;
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    done_cnt = 0; wr_cnt = 0;
    repeat (5) step(1'b0);
    chk("no_done_after_rst", 64'(done_cnt), 64'd0);
    resp_q.push_back('{due: cyc, data: mkdata(64'h1234_5678)});
    step(1'b0);
    chk("stray_resp_grant", 64'(last_resp_grant), 64'd1);
    step(1'b0);
    chk("stray_err_set", 64'(err_stray_resp), 64'd1);
    chk("stray_no_write", 64'(last_wr_valid), 64'd0);
    repeat (3) step(1'b0);
    chk("stray_err_sticky", 64'(err_stray_resp), 64'd1);
    chk("stray_no_writes", 64'(wr_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
